// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle logic/arithmetic/pass ops, shifts and rotates
// applied one bit per clock, with a valid/ready handshake on each side.
module iter_alu #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             invA,
    input  logic             invB,
    input  logic             cin,
    input  logic             sign,
    input  logic             passA,
    input  logic             passB,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ofl,
    output logic             zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Low two op bits select the shift flavour: 00 ROL, 01 SLL, 10 ROR, 11 SRL.
    typedef enum logic [1:0] {
        DIR_ROL = 2'b00,
        DIR_SLL = 2'b01,
        DIR_ROR = 2'b10,
        DIR_SRL = 2'b11
    } dir_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    dir_e               dir_q, dir_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               ofl_q, ofl_d;

    logic [WIDTH-1:0]   a_i, b_i;
    logic [WIDTH:0]     sum;
    logic               add_ovf;
    logic [WIDTH-1:0]   acc_step;

    function automatic logic [WIDTH-1:0] shift_one(input dir_e dir, input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        case (dir)
            DIR_ROL: r = {v[WIDTH-2:0], v[WIDTH-1]};
            DIR_SLL: r = {v[WIDTH-2:0], 1'b0};
            DIR_ROR: r = {v[0], v[WIDTH-1:1]};
            default: r = {1'b0, v[WIDTH-1:1]};
        endcase
        return r;
    endfunction

    assign a_i      = invA ? ~A : A;
    assign b_i      = invB ? ~B : B;
    assign sum      = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin};
    assign add_ovf  = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
    assign acc_step = shift_one(dir_q, acc_q);

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        result_d = result_q;
        ofl_d    = ofl_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = DONE;
                    ofl_d   = 1'b0;
                    if (passB) begin
                        result_d = B;
                    end else if (passA) begin
                        result_d = A;
                    end else if (op[2]) begin
                        case (op[1:0])
                            2'b00: begin
                                result_d = sum[WIDTH-1:0];
                                ofl_d    = sign ? add_ovf : sum[WIDTH];
                            end
                            2'b01:   result_d = a_i | b_i;
                            2'b10:   result_d = a_i ^ b_i;
                            default: result_d = a_i & b_i;
                        endcase
                    end else begin
                        acc_d = a_i;
                        cnt_d = B[SHAMT_W-1:0];
                        dir_d = dir_e'(op[1:0]);
                        if (B[SHAMT_W-1:0] == '0) begin
                            result_d = a_i;
                        end else begin
                            state_d = SHIFT;
                        end
                    end
                end
            end
            SHIFT: begin
                acc_d = acc_step;
                cnt_d = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    result_d = acc_step;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            dir_q    <= DIR_ROL;
            result_q <= '0;
            ofl_q    <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            result_q <= result_d;
            ofl_q    <= ofl_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign ofl       = ofl_q;
    assign zero      = (result_q == '0);

endmodule

// File: tb/tb_iter_alu.sv
// Directed, table-driven bench for iter_alu plus hand-written sequences for
// backpressure and reset-during-shift.
module tb_iter_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A, B;
    logic        invA, invB, cin, sign, passA, passB;
    logic [2:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        ofl;
    logic        zero;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic        inva;
        logic        invb;
        logic        cin;
        logic        sgn;
        logic        pa;
        logic        pb;
        logic [2:0]  op;
        logic [15:0] res;
        logic        ofl;
        int          edges;   // posedges after the accept edge until out_valid
    } vec_t;

    vec_t vecs[$];

    iter_alu #(.WIDTH(16), .SHAMT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .invA      (invA),
        .invB      (invB),
        .cin       (cin),
        .sign      (sign),
        .passA     (passA),
        .passB     (passB),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ofl       (ofl),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic inva, input logic invb, input logic c, input logic sg,
                           input logic pa, input logic pb, input logic [2:0] o,
                           input logic [15:0] res, input logic of, input int edges);
        vec_t v;
        v.name = name; v.a = a; v.b = b; v.inva = inva; v.invb = invb; v.cin = c;
        v.sgn = sg; v.pa = pa; v.pb = pb; v.op = o; v.res = res; v.ofl = of; v.edges = edges;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        A = v.a; B = v.b; invA = v.inva; invB = v.invb; cin = v.cin;
        sign = v.sgn; passA = v.pa; passB = v.pb; op = v.op;
    endtask

    task automatic scramble_inputs();
        A = ~A; B = ~B; invA = ~invA; invB = ~invB; cin = ~cin;
        sign = ~sign; passA = ~passA; passB = ~passB; op = ~op;
    endtask

    // Present one op in IDLE, wait for out_valid, check it, then drain it.
    task automatic run_op(input vec_t v);
        int n;
        @(negedge clk);
        check({v.name, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        drive(v);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        scramble_inputs();
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({v.name, ".edges"}, 32'(n), 32'(v.edges));
        check({v.name, ".result"}, 32'(result), 32'(v.res));
        check({v.name, ".ofl"}, 32'(ofl), 32'(v.ofl));
        check({v.name, ".zero"}, 32'(zero), 32'(v.res == 16'h0000));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({v.name, ".back_idle"}, {31'd0, in_ready & ~out_valid}, 32'd1);
    endtask

    initial begin
        vec_t v;
        int   n;

        //      name        A        B      iA iB ci sg pA pB op      result  ofl edges
        add_vec("add_sovf", 16'h7FFF, 16'h0001, 0, 0, 0, 1, 0, 0, 3'b100, 16'h8000, 1, 0);
        add_vec("sub_eq",   16'h0005, 16'h0005, 1, 0, 1, 0, 0, 0, 3'b100, 16'h0000, 1, 0);
        add_vec("rol4",     16'h8001, 16'h0004, 0, 0, 0, 0, 0, 0, 3'b000, 16'h0018, 0, 4);
        add_vec("srl15",    16'h8000, 16'h000F, 0, 0, 0, 0, 0, 0, 3'b011, 16'h0001, 0, 15);
        add_vec("sll0",     16'h1234, 16'h0010, 0, 0, 0, 0, 0, 0, 3'b001, 16'h1234, 0, 0);
        add_vec("passb",    16'hFFFF, 16'h00AB, 0, 0, 0, 0, 0, 1, 3'b000, 16'h00AB, 0, 0);
        add_vec("passa",    16'h5A5A, 16'h0003, 1, 0, 0, 0, 1, 0, 3'b000, 16'h5A5A, 0, 0);
        add_vec("or_invb",  16'h00F0, 16'hFF0F, 0, 1, 0, 0, 0, 0, 3'b101, 16'h00F0, 0, 0);
        add_vec("xor",      16'h00FF, 16'h0F0F, 0, 0, 0, 0, 0, 0, 3'b110, 16'h0FF0, 0, 0);
        add_vec("and",      16'hF0F0, 16'hFF00, 0, 0, 0, 0, 0, 0, 3'b111, 16'hF000, 0, 0);
        add_vec("ror1",     16'h0001, 16'h0001, 0, 0, 0, 0, 0, 0, 3'b010, 16'h8000, 0, 1);
        add_vec("sll3",     16'h8001, 16'h0003, 0, 0, 0, 0, 0, 0, 3'b001, 16'h0008, 0, 3);
        add_vec("add_wrap", 16'hFFFF, 16'h0001, 0, 0, 0, 1, 0, 0, 3'b100, 16'h0000, 0, 0);
        add_vec("add_novf", 16'h8000, 16'h8000, 0, 0, 0, 1, 0, 0, 3'b100, 16'h0000, 1, 0);
        add_vec("rol_inva", 16'h0FFF, 16'h0002, 1, 0, 0, 0, 0, 0, 3'b000, 16'hC003, 0, 2);
        add_vec("add_cin",  16'h1234, 16'h1111, 0, 0, 1, 0, 0, 0, 3'b100, 16'h2346, 0, 0);
        add_vec("srl8_hib", 16'hABCD, 16'hFFF8, 0, 0, 0, 0, 0, 0, 3'b011, 16'h00AB, 0, 8);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; invA = 0; invB = 0; cin = 0; sign = 0; passA = 0; passB = 0; op = '0;
        #1;
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.result", 32'(result), 32'd0);
        check("rst.ofl", 32'(ofl), 32'd0);
        check("rst.zero", 32'(zero), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_op(vecs[i]);

        // Backpressure: DONE must hold and ignore new requests while out_ready=0.
        @(negedge clk);
        drive(vecs[0]);
        in_valid = 1'b1;
        @(negedge clk);
        A = 16'h0F0F; B = 16'h3333; op = 3'b110; sign = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("bp.out_valid", 32'(out_valid), 32'd1);
            check("bp.in_ready", 32'(in_ready), 32'd0);
            check("bp.result", 32'(result), 32'h8000);
            check("bp.ofl", 32'(ofl), 32'd1);
            check("bp.zero", 32'(zero), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp.release_idle", 32'(in_ready), 32'd1);
        check("bp.release_ov", 32'(out_valid), 32'd0);
        check("bp.release_res", 32'(result), 32'h8000);
        // in_valid is still high: the XOR request is taken now.
        @(negedge clk);
        in_valid = 1'b0;
        check("bp.next_ov", 32'(out_valid), 32'd1);
        check("bp.next_res", 32'(result), 32'h3C3C);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in SHIFT with cnt=7: ROL by 10, then three shift edges.
        drive(vecs[2]);
        B = 16'h000A;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rs.in_shift", 32'(in_ready | out_valid), 32'd0);
        #1 rst = 1'b1;
        #1;
        check("rs.out_valid", 32'(out_valid), 32'd0);
        check("rs.in_ready", 32'(in_ready), 32'd1);
        check("rs.result", 32'(result), 32'd0);
        check("rs.zero", 32'(zero), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        check("rs.no_stale_valid", 32'(n), 32'd0);
        v = vecs[8];
        run_op(v);

        // Reset while in DONE also discards the result.
        drive(vecs[9]);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("rd.done", 32'(out_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rd.out_valid", 32'(out_valid), 32'd0);
        check("rd.result", 32'(result), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(vecs[14]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 Parameter WIDTH, default 16, datapath width; all width rules below assume 16.
REQ-002 Parameter SHAMT_W, default 4, shift-amount width taken from B[SHAMT_W-1:0].
REQ-003 Clock and reset SHALL be clk and rst: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 in_valid  in  1  operation presented.
REQ-007 in_ready  out  1  unit can accept (high only in IDLE).
REQ-008 A, B  in  16  operands.
REQ-009 invA, invB, cin, sign, passA, passB  in  1 each  ALU-control decode outputs.
REQ-010 op  in  3  op_to_alu: 000 ROL, 001 SLL, 010 ROR, 011 SRL, 100 ADD, 101 OR, 110 XOR, 111 AND.
REQ-011 out_valid  out  1  result available.
REQ-012 out_ready  in  1  consumer takes result.
REQ-013 result  out  16  registered result.
REQ-014 ofl  out  1  overflow/carry flag.
REQ-015 zero  out  1  result == 0.

Function
REQ-016 The FSM SHALL have states IDLE, SHIFT and DONE; in_ready = (state==IDLE) and out_valid = (state==DONE).
REQ-017 Accept SHALL occur on an edge with in_valid && in_ready; all inputs are captured then, and later input changes SHALL be ignored until the next accept.
REQ-018 Operand conditioning: Ai = invA ? ~A : A and Bi = invB ? ~B : B.
REQ-019 Priority: passB -> result=B; otherwise passA -> result=A; both are raw, 1-cycle ops with ofl=0.
REQ-020 ADD: result = (Ai + Bi + cin) mod 2^16; sign=1 -> ofl = (Ai[15]==Bi[15]) && (result[15]!=Ai[15]); sign=0 -> ofl = carry-out of bit 15.
REQ-021 OR, XOR and AND SHALL operate on Ai and Bi with ofl=0.
REQ-022 Non-shift ops: the accept edge SHALL load result/ofl/zero and move to DONE, so out_valid is high in the cycle after accept (latency 1).
REQ-023 Shift ops: shamt = B[3:0], raw; accept edge loads acc=Ai, cnt=shamt; shamt==0 -> DONE directly with result=Ai (latency 1); else -> SHIFT.
REQ-024 In SHIFT, each edge SHALL apply a 1-bit operation to acc and decrement cnt: ROL/ROR rotate, SLL fills 0 at LSB, SRL fills 0 at MSB.
REQ-025 The edge on which cnt reaches 0 SHALL enter DONE with result=acc; total latency is shamt edges after accept, and shift ops set ofl=0.
REQ-026 zero SHALL be derived from the registered result.
REQ-027 DONE holds result, ofl and zero stable while out_ready=0; an edge with out_valid && out_ready returns to IDLE, and no accept is possible in that same cycle.
REQ-028 Minimum throughput is one op per 2 cycles; in_valid outside IDLE has no effect.

Reset
REQ-029 rst asserted SHALL immediately force state=IDLE, result=0x0000, ofl=0, zero=1, out_valid=0, in_ready=1, cnt=0 and acc=0.
REQ-030 rst asserted mid-SHIFT or in DONE SHALL discard the operation; no out_valid follows, and the first post-reset accept behaves normally.

Verification
REQ-031 ADD: A=0x7FFF, B=0x0001, sign=1, op=100 -> next cycle out_valid=1, result=0x8000, ofl=1, zero=0.
REQ-032 SUB form: invA=1, cin=1, A=B=0x0005, sign=0, op=100 -> result=0x0000, zero=1, ofl=1 (carry).
REQ-033 Shifts: ROL A=0x8001, B=0x0004 -> result 0x0018 with out_valid 4 cycles after accept; SRL A=0x8000, B=0x000F -> 0x0001 after 15 cycles; SLL A=0x1234, B=0x0010 (shamt 0) -> 0x1234, latency 1.
REQ-034 Pass: passB=1, A=0xFFFF, B=0x00AB, op=000 -> result 0x00AB, latency 1, ofl=0.
REQ-035 Backpressure: out_ready=0 for 3 cycles in DONE with in_valid=1 and new operands -> result and flags unchanged, in_ready=0, no new accept; out_ready=1 -> IDLE next edge.
REQ-036 Reset: rst pulsed while in SHIFT with cnt=7 -> same instant out_valid=0, in_ready=1, result=0x0000; the following XOR A=0x00FF, B=0x0F0F gives 0x0FF0.
